// File: rtl/anu_fifo_cdc_if.sv
// Pin bundle of the Tiny Tapeout user project wrapping the 8x8 Gray-pointer FIFO.
// master: drives ena, ui_in (write data), uio_in ([0]=wr_en, [1]=rd_en).
// slave : drives uo_out (read data), uio_out (status flags), uio_oe (pin directions).
interface anu_fifo_cdc_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/anu_fifo_cdc.sv
// Eight-entry, 8-bit FIFO built as a Gray-pointer asynchronous FIFO with both
// pointer domains on the single project clock, showing the two-flop pointer
// synchronizer technique.
// Ports:
//   clk   - project clock, clocks both the write and the read side
//   rst_n - asynchronous active-low reset
//   bus   - pin bundle: ui_in = write data; uio_in[0] = wr_en, uio_in[1] = rd_en;
//           uo_out = registered read data; uio_out[2] = full, [3] = empty,
//           [4] = sticky overflow, [5] = sticky underflow; uio_oe = 8'hFC.
module anu_fifo_cdc (
  input  logic          clk,
  input  logic          rst_n,
  anu_fifo_cdc_if.slave bus
);

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned DEPTH = 8;

  logic [DW-1:0] mem [DEPTH];

  logic [PW-1:0] wptr_bin;
  logic [PW-1:0] wptr_gray;
  logic [PW-1:0] rptr_bin;
  logic [PW-1:0] rptr_gray;
  logic [PW-1:0] wq1;
  logic [PW-1:0] wq2;
  logic [PW-1:0] rq1;
  logic [PW-1:0] rq2;
  logic [DW-1:0] rdata;
  logic          overflow;
  logic          underflow;

  logic          wr_en_c;
  logic          rd_en_c;
  logic          full_c;
  logic          empty_c;
  logic          do_wr_c;
  logic          do_rd_c;
  logic [PW-1:0] wptr_bin_next_c;
  logic [PW-1:0] rptr_bin_next_c;
  logic          unused_c;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign wr_en_c = bus.uio_in[0];
  assign rd_en_c = bus.uio_in[1];

  // ena and the upper uio_in bits have no function in this design
  assign unused_c = &{1'b0, bus.ena, bus.uio_in[7:2]};

  // Flags compare a local pointer against the synchronized remote one, so they
  // are pessimistic by the two-flop synchronizer delay.
  assign empty_c = (rptr_gray == wq2);
  assign full_c  = (wptr_gray == {~rq2[PW-1:PW-2], rq2[PW-3:0]});

  assign do_wr_c = wr_en_c & ~full_c;
  assign do_rd_c = rd_en_c & ~empty_c;

  assign wptr_bin_next_c = wptr_bin + PW'(1);
  assign rptr_bin_next_c = rptr_bin + PW'(1);

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (do_wr_c) begin
      mem[wptr_bin[AW-1:0]] <= bus.ui_in;
    end
  end

  // Pointers, synchronizers, read data and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_bin  <= '0;
      wptr_gray <= '0;
      rptr_bin  <= '0;
      rptr_gray <= '0;
      wq1       <= '0;
      wq2       <= '0;
      rq1       <= '0;
      rq2       <= '0;
      rdata     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wq1 <= wptr_gray;
      wq2 <= wq1;
      rq1 <= rptr_gray;
      rq2 <= rq1;
      if (do_wr_c) begin
        wptr_bin  <= wptr_bin_next_c;
        wptr_gray <= bin2gray(wptr_bin_next_c);
      end
      if (do_rd_c) begin
        rdata     <= mem[rptr_bin[AW-1:0]];
        rptr_bin  <= rptr_bin_next_c;
        rptr_gray <= bin2gray(rptr_bin_next_c);
      end
      if (wr_en_c && full_c) begin
        overflow <= 1'b1;
      end
      if (rd_en_c && empty_c) begin
        underflow <= 1'b1;
      end
    end
  end

  assign bus.uo_out  = rdata;
  assign bus.uio_out = {2'b00, underflow, overflow, empty_c, full_c, 2'b00};
  assign bus.uio_oe  = 8'b1111_1100;

endmodule

// File: tb/tb_anu_fifo_cdc.sv
// Directed testbench for anu_fifo_cdc: reset, single byte latency, fill/overflow
// ordering, underflow, pointer wrap under concurrent traffic, and reset mid-stream.
module tb_anu_fifo_cdc;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  anu_fifo_cdc_if bus ();

  anu_fifo_cdc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n      = 1'b0;
    bus.uio_in = 8'h00;
    repeat (n) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.uio_in = 8'h00;
    bus.ui_in  = 8'h00;
    repeat (5) tick();
    vectors++;
    if (bus.uo_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_uo_out: got %h expected %h", bus.uo_out, 8'h00);
    end
    vectors++;
    if (bus.uio_out !== 8'h08) begin
      miscompares++;
      $display("FAIL reset_uio_out: got %h expected %h", bus.uio_out, 8'h08);
    end
    vectors++;
    if (bus.uio_oe !== 8'hFC) begin
      miscompares++;
      $display("FAIL reset_uio_oe: got %h expected %h", bus.uio_oe, 8'hFC);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus.ui_in  = 8'hA5;
    bus.uio_in = 8'h01;
    tick();
    bus.uio_in = 8'h00;
    tick();
    vectors++;
    if (bus.uio_out[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL single_empty_n1: got %b expected %b", bus.uio_out[3], 1'b1);
    end
    tick();
    vectors++;
    if (bus.uio_out[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL single_empty_n2: got %b expected %b", bus.uio_out[3], 1'b0);
    end
    tick();
    bus.uio_in = 8'h02;
    tick();
    bus.uio_in = 8'h00;
    vectors++;
    if (bus.uo_out !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_data: got %h expected %h", bus.uo_out, 8'hA5);
    end
    repeat (3) tick();
    vectors++;
    if (bus.uio_out !== 8'h08) begin
      miscompares++;
      $display("FAIL single_flags_after: got %h expected %h", bus.uio_out, 8'h08);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      bus.ui_in  = 8'(i + 1);
      bus.uio_in = 8'h01;
      tick();
      if (i == 6) begin
        vectors++;
        if (bus.uio_out[2] !== 1'b0) begin
          miscompares++;
          $display("FAIL fill_full_after7: got %b expected %b", bus.uio_out[2], 1'b0);
        end
      end
    end
    vectors++;
    if (bus.uio_out !== 8'h04) begin
      miscompares++;
      $display("FAIL fill_full_after8: got %h expected %h", bus.uio_out, 8'h04);
    end
    bus.ui_in = 8'h09;
    tick();
    bus.uio_in = 8'h00;
    vectors++;
    if (bus.uio_out !== 8'h14) begin
      miscompares++;
      $display("FAIL fill_overflow: got %h expected %h", bus.uio_out, 8'h14);
    end
    for (int i = 0; i < 8; i++) begin
      bus.uio_in = 8'h02;
      tick();
      vectors++;
      if (bus.uo_out !== 8'(i + 1)) begin
        miscompares++;
        $display("FAIL fill_read%0d: got %h expected %h", i, bus.uo_out, 8'(i + 1));
      end
      if (i < 2) begin
        vectors++;
        if (bus.uio_out[2] !== 1'b1) begin
          miscompares++;
          $display("FAIL fill_full_hold%0d: got %b expected %b", i, bus.uio_out[2], 1'b1);
        end
      end else if (i == 2) begin
        vectors++;
        if (bus.uio_out[2] !== 1'b0) begin
          miscompares++;
          $display("FAIL fill_full_release: got %b expected %b", bus.uio_out[2], 1'b0);
        end
      end
    end
    bus.uio_in = 8'h00;
    vectors++;
    if (bus.uio_out !== 8'h18) begin
      miscompares++;
      $display("FAIL fill_drained_flags: got %h expected %h", bus.uio_out, 8'h18);
    end
    repeat (3) tick();
    vectors++;
    if (bus.uo_out !== 8'h08) begin
      miscompares++;
      $display("FAIL fill_no_extra: got %h expected %h", bus.uo_out, 8'h08);
    end
  endtask

  task automatic test_underflow();
    do_reset(2);
    bus.ui_in  = 8'h5C;
    bus.uio_in = 8'h01;
    tick();
    bus.uio_in = 8'h00;
    repeat (2) tick();
    bus.uio_in = 8'h02;
    tick();
    vectors++;
    if (bus.uo_out !== 8'h5C) begin
      miscompares++;
      $display("FAIL underflow_setup: got %h expected %h", bus.uo_out, 8'h5C);
    end
    tick();
    bus.uio_in = 8'h00;
    vectors++;
    if (bus.uio_out !== 8'h28) begin
      miscompares++;
      $display("FAIL underflow_flag: got %h expected %h", bus.uio_out, 8'h28);
    end
    vectors++;
    if (bus.uo_out !== 8'h5C) begin
      miscompares++;
      $display("FAIL underflow_hold: got %h expected %h", bus.uo_out, 8'h5C);
    end
    do_reset(2);
    vectors++;
    if (bus.uio_out !== 8'h08) begin
      miscompares++;
      $display("FAIL underflow_cleared: got %h expected %h", bus.uio_out, 8'h08);
    end
  endtask

  task automatic test_wrap();
    int   widx;
    int   ridx;
    int   cyc;
    logic rd;
    logic wr;
    widx = 0;
    ridx = 0;
    cyc  = 0;
    while (ridx < 20 && cyc < 200) begin
      wr         = (widx < 20);
      rd         = ~bus.uio_out[3];
      bus.ui_in  = 8'(8'h10 + widx);
      bus.uio_in = {6'b0, rd, wr};
      tick();
      cyc++;
      if (rd) begin
        vectors++;
        if (bus.uo_out !== 8'(8'h10 + ridx)) begin
          miscompares++;
          $display("FAIL wrap_read%0d: got %h expected %h", ridx, bus.uo_out, 8'(8'h10 + ridx));
        end
        ridx++;
      end
      if (wr) widx++;
    end
    bus.uio_in = 8'h00;
    vectors++;
    if (ridx != 20) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d expected %0d", ridx, 20);
    end
    vectors++;
    if (bus.uio_out !== 8'h08) begin
      miscompares++;
      $display("FAIL wrap_flags: got %h expected %h", bus.uio_out, 8'h08);
    end
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 5; i++) begin
      bus.ui_in  = 8'(8'h31 + i);
      bus.uio_in = 8'h01;
      tick();
    end
    bus.uio_in = 8'h00;
    repeat (2) tick();
    vectors++;
    if (bus.uio_out !== 8'h00) begin
      miscompares++;
      $display("FAIL midreset_pre: got %h expected %h", bus.uio_out, 8'h00);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.uio_out !== 8'h08) begin
      miscompares++;
      $display("FAIL midreset_flags: got %h expected %h", bus.uio_out, 8'h08);
    end
    vectors++;
    if (bus.uo_out !== 8'h00) begin
      miscompares++;
      $display("FAIL midreset_data: got %h expected %h", bus.uo_out, 8'h00);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    bus.uio_in = 8'h02;
    tick();
    bus.uio_in = 8'h00;
    vectors++;
    if (bus.uio_out !== 8'h28) begin
      miscompares++;
      $display("FAIL midreset_discarded: got %h expected %h", bus.uio_out, 8'h28);
    end
    vectors++;
    if (bus.uo_out !== 8'h00) begin
      miscompares++;
      $display("FAIL midreset_no_data: got %h expected %h", bus.uo_out, 8'h00);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.ena     = 1'b1;
    bus.ui_in   = 8'h00;
    bus.uio_in  = 8'h00;
    test_reset();
    test_single();
    test_fill();
    test_underflow();
    test_wrap();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
